// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshakes.
// Logic/arith ops finish in one cycle; shifts iterate one bit per cycle.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } shop_t;

    state_t           state_q, state_d;
    shop_t            sh_q, sh_d, sh_sel;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic             op_add, op_sub, op_and, op_or, op_slt;
    logic             is_shift;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] imm_res;
    logic [WIDTH-1:0] step;
    logic             slt_bit;

    assign op_add   = (alu_control == 3'b000);
    assign op_sub   = (alu_control == 3'b001);
    assign op_and   = (alu_control == 3'b010);
    assign op_or    = (alu_control == 3'b011);
    assign op_slt   = (alu_control == 3'b101);
    assign is_shift = alu_control[2] && !op_slt;
    assign shamt    = src_b[SHW-1:0];
    assign slt_bit  = $signed(src_a) < $signed(src_b);

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;

    // Single-cycle result; a zero-distance shift passes src_a through.
    always_comb begin
        imm_res = src_a;
        unique case (1'b1)
            op_add:  imm_res = src_a + src_b;
            op_sub:  imm_res = src_a - src_b;
            op_and:  imm_res = src_a & src_b;
            op_or:   imm_res = src_a | src_b;
            op_slt:  imm_res = {{(WIDTH-1){1'b0}}, slt_bit};
            default: imm_res = src_a;
        endcase
    end

    // Map the shift opcode onto the internal shift kind.
    always_comb begin
        sh_sel = SH_SLL;
        case (alu_control)
            3'b110:  sh_sel = SH_SRL;
            3'b111:  sh_sel = SH_SRA;
            default: sh_sel = SH_SLL;
        endcase
    end

    // One-bit shift of the accumulator.
    always_comb begin
        step = acc_q;
        case (sh_q)
            SH_SLL:  step = {acc_q[WIDTH-2:0], 1'b0};
            SH_SRL:  step = {1'b0, acc_q[WIDTH-1:1]};
            SH_SRA:  step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: step = acc_q;
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (is_shift && (shamt != '0)) begin
                        acc_d   = src_a;
                        cnt_d   = shamt;
                        sh_d    = sh_sel;
                        state_d = S_SHIFT;
                    end else begin
                        result_d = imm_res;
                        zero_d   = (imm_res == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = step;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d = step;
                    zero_d   = (step == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sh_q     <= SH_SLL;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Sequential execution unit that consumes the 3-bit ALUControl code produced by the ALU decoder and executes the selected operation on two operands.
- Completes logical and arithmetic ops in one registered cycle.
- Performs shifts iteratively, one bit position per cycle, using a small FSM.
- Sits in the execute stage of the multi-cycle datapath variant, with valid/ready handshakes toward control (input) and writeback (output).

Parameters:
- WIDTH, 32, operand and result width in bits; must be a power of 2, at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived localparam, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request (high only in IDLE).
- alu_control  input  3  operation code; 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT, 100 SLL, 110 SRL, 111 SRA.
- src_a  input  WIDTH  operand A; the shifted value for shift ops.
- src_b  input  WIDTH  operand B; shift amount is src_b[SHW-1:0], upper bits ignored.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  registered flag, high when result == 0.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, shift counter=0.
- States:
  - IDLE: in_ready=1. The request is accepted on an edge with in_valid=1.
  - SHIFT: iterating. in_ready=0, out_valid=0.
  - DONE: out_valid=1. result and zero are held stable.
- IDLE transitions (acceptance cycle is N):
  - Non-shift op, or shift with shamt=0: result and zero are registered; next state is DONE; out_valid is first high in cycle N+1.
  - Shift with shamt>0: accumulator loads src_a, counter loads shamt, next state is SHIFT.
- SHIFT:
  - Each edge shifts the accumulator by 1 and decrements the counter.
  - SLL fills with 0. SRL fills with 0. SRA fills with the accumulator MSB.
  - The edge on which counter==1 writes the final value to result, updates zero, and moves to DONE.
  - out_valid is first high in cycle N+1+shamt.
- DONE: leaves to IDLE on an edge with out_valid && out_ready. in_ready rises the next cycle; there is no same-cycle re-accept.
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^WIDTH; there is no overflow or carry output.
  - SLT is signed two's-complement compare; result = {WIDTH-1 zeros, (a<b)}.
  - AND and OR are bitwise.
- Operands and alu_control are sampled only at acceptance. Changes on these inputs while in SHIFT or DONE have no effect.
- in_valid while not in IDLE is ignored; the request is not queued. The requester must hold it until in_ready.
- out_ready while not in DONE is ignored.
- Backpressure: DONE holds indefinitely. result, zero and out_valid do not change until the handshake completes.
- Reset mid-operation, in any state: next edge returns to reset values. An in-flight operation is discarded and no out_valid pulse is produced.
- rst has priority over in_valid and out_ready on the same edge.
- Maximum latency is WIDTH cycles (shamt = WIDTH-1).

Test Plan:
- rst held 2 cycles, then released:
  - expect in_ready=1, out_valid=0, result=0, zero=0.
  - in_valid with ADD 0x7FFFFFFF+1 accepted in cycle N → out_valid in N+1, result=0x80000000, zero=0.
- SUB 5-5 → result=0, zero=1.
- SUB 0-1 → 0xFFFFFFFF.
- SLT a=0xFFFFFFFF (-1), b=1 → result=1.
- SLT a=1, b=0xFFFFFFFF → result=0.
- AND 0xF0F0F0F0&0xFF00FF00 → 0xF000F000.
- OR → 0xFFF0FFF0.
- SLL a=0x1, b=0x24 (shamt=4) accepted in N:
  - in_ready=0 during N+1..N+4.
  - out_valid first in N+5, result=0x10.
- SRA a=0x80000000, shamt=31 → out_valid in N+32, result=0xFFFFFFFF.
- SRL same operands → 0x00000001.
- Shift with shamt=0 → out_valid in N+1, result=src_a.
- Backpressure: out_ready=0 for 10 cycles after out_valid:
  - result and zero remain stable; a second in_valid is ignored (in_ready=0).
  - Then out_ready=1 → IDLE next cycle; the second request is accepted only once in_ready=1.
- Reset mid-shift: SLL shamt=20, rst asserted in cycle N+5:
  - next cycle state is IDLE, out_valid=0, result=0.
  - No result appears afterwards.
